mul_share_arbiter: RTL

- Round-robin arbiter and pipeline sequencer that shares one combinational 16x16 unsigned Wallace multiplier among NREQ requesters in the k-means datapath, e.g. distance-squared units and centroid update.
- Registers the winning operands into the multiplier inputs and captures the product one cycle later.
- Returns the product on a single tagged response bus with backpressure.

---
 rtl/mul_share_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one external 16x16 multiplier among NREQ requesters.
// S1 registers the winning operands; S2 captures the product as a tagged response.
`timescale 1ns/1ps
module mul_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic [35:0]          mul_p,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_data,
  input  logic                 rsp_ready,
  output logic                 err_hi
);

  logic           s1_valid;
  logic [IDW-1:0] s1_id;
  logic [IDW-1:0] rr_ptr;

  logic           stall;
  logic           s1_adv;
  logic           can_accept;
  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic [15:0]    win_a;
  logic [15:0]    win_b;
  logic           xfer;
  int             idx;

  assign stall      = rsp_valid & ~rsp_ready;
  assign s1_adv     = s1_valid & ~stall;
  assign can_accept = ~s1_valid | s1_adv;

  // Circular search starting just after the last winner; constant indices
  // only, so the search unrolls into a priority chain per offset.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(rr_ptr) + off) % NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_found && (idx == i) && req_valid[i]) begin
          grant_found = 1'b1;
          grant_id    = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    win_a     = '0;
    win_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        req_ready[i] = rst_n & can_accept & grant_found;
        win_a        = req_a[16*i +: 16];
        win_b        = req_b[16*i +: 16];
      end
    end
  end

  assign xfer = |(req_valid & req_ready);

  // Operands are left as-is when S1 empties; only s1_valid marks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a    <= '0;
      mul_b    <= '0;
      s1_id    <= '0;
      s1_valid <= 1'b0;
      rr_ptr   <= IDW'(NREQ-1);
    end else if (xfer) begin
      mul_a    <= win_a;
      mul_b    <= win_b;
      s1_id    <= grant_id;
      s1_valid <= 1'b1;
      rr_ptr   <= grant_id;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      err_hi    <= 1'b0;
    end else if (s1_adv) begin
      rsp_valid <= 1'b1;
      rsp_id    <= s1_id;
      rsp_data  <= mul_p[31:0];
      if (|mul_p[35:32]) err_hi <= 1'b1;
    end else if (!stall) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
